// File: rtl/serial_sum_sched.sv
// Round-robin scheduler sharing one serial three-operand sum datapath among N_REQ requesters.
// Optional start-to-done watchdog: define SERIAL_SUM_SCHED_TMO_EN.
module serial_sum_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 27,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TMO_CYC = 1023
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic                      dp_start_o,
  output logic [DATA_W-1:0]         dp_data_o,
  input  logic                      dp_done_i,
  output logic                      done_o,
  output logic [2:0]                done_id_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned ID_W  = 3;
  localparam int unsigned GAP_W = 4;
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
  localparam int unsigned CNT_W = (TMO_W > GAP_W) ? TMO_W : GAP_W;
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                pick_vld;
  logic [ID_W-1:0]     pick_id;
  logic [DATA_W-1:0]   pick_word;
  logic                job_end;

  // First set request at or after ptr, searched cyclically.
  always_comb begin : pick_comb
    pick_vld  = 1'b0;
    pick_id   = '0;
    pick_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!pick_vld && req_i[j] && (ptr_q == ID_W'((j + N_REQ - i) % N_REQ))) begin
          pick_vld  = 1'b1;
          pick_id   = ID_W'(j);
          pick_word = data_i[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin : fsm_comb
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    start_d   = 1'b0;
    data_d    = data_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    busy_d    = busy_q;
    err_d     = err_q;
    job_end   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = N_REQ'(1) << pick_id;
          data_d  = pick_word;
          id_d    = pick_id;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dp_done_i) begin
          job_end = 1'b1;
`ifdef SERIAL_SUM_SCHED_TMO_EN
        end else if (cnt_q == CNT_W'(TMO_CYC)) begin
          job_end = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
        // A finished or abandoned job releases the datapath and rotates priority.
        if (job_end) begin
          done_d    = 1'b1;
          done_id_d = id_q;
          ptr_d     = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);
          cnt_d     = '0;
          if (GAP_CYC > 0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin : state_reg
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      start_q   <= start_d;
      data_q    <= data_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign dp_start_o = start_q;
  assign dp_data_o  = data_q;
  assign done_o     = done_q;
  assign done_id_o  = done_id_q;
  assign busy_o     = busy_q;
`ifdef SERIAL_SUM_SCHED_TMO_EN
  assign err_o      = err_q;
`else
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sum_sched.sv
// Scoreboard bench for serial_sum_sched: expected grant order from a round-robin model,
// datapath stand-in with configurable latency, negedge monitor checking every output event.
module tb_serial_sum_sched;

  localparam int N   = 4;
  localparam int W   = 27;
  localparam int GAP = 2;
  localparam int TMO = 50;
  localparam int LAT = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   data;
  logic [N-1:0]     gnt;
  logic             dp_start;
  logic [W-1:0]     dp_data;
  logic             dp_done;
  logic             done;
  logic [2:0]       done_id;
  logic             busy;
  logic             err;

  serial_sum_sched #(
    .N_REQ(N), .DATA_W(W), .GAP_CYC(GAP), .TMO_CYC(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .gnt_o(gnt),
    .dp_start_o(dp_start), .dp_data_o(dp_data), .dp_done_i(dp_done),
    .done_o(done), .done_id_o(done_id), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [W-1:0] word;
  } job_t;

  job_t exp_q[$];
  int   start_log[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_gnt_seen = 0;
  int   n_gnt_exp = 0;
  int   model_ptr = 0;
  int   spur_cnt = 0;
  int   dp_lat = LAT;
  logic dp_auto = 1'b1;
  logic dp_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Datapath stand-in: done pulse dp_lat cycles after start, plus injectable stray pulses.
  initial begin : dp_model
    int rem;
    int spur_seen;
    rem = -1;
    spur_seen = 0;
    dp_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dp_done = 1'b0;
      if (dp_start && dp_auto) rem = dp_rand ? int'($urandom_range(0, 12)) : dp_lat;
      if (spur_cnt != spur_seen) begin
        spur_seen++;
        dp_done = 1'b1;
      end else if (rem == 0) begin
        dp_done = 1'b1;
        rem = -1;
      end else if (rem > 0) begin
        rem--;
      end
    end
  end

  // Monitor: pops expectations on grants and checks start, data and done behaviour.
  job_t pend;
  logic in_job = 1'b0;
  logic exp_done = 1'b0;
  logic exp_tmo = 1'b0;
  logic err_exp = 1'b0;
  int   gnt_cyc = 0;
  int   start_cyc = 0;
  int   done_cyc = -1000;

  always @(negedge clk) begin : monitor
    if (rst) begin
      exp_q.delete();
      in_job   = 1'b0;
      exp_done = 1'b0;
      exp_tmo  = 1'b0;
      err_exp  = 1'b0;
      done_cyc = -1000;
    end else begin
      if (done || exp_done) begin
        check("done_pulse", 32'(done), 32'(exp_done));
        if (done && exp_done) begin
          if (exp_tmo) err_exp = 1'b1;
          check("done_id", 32'(done_id), 32'(pend.id));
          check("done_err", 32'(err), 32'(err_exp));
          check("data_hold", 32'(dp_data), 32'(pend.word));
          done_cyc = cyc;
        end
        exp_done = 1'b0;
        exp_tmo  = 1'b0;
      end
      if (gnt != '0) begin
        n_gnt_seen++;
        check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        check("gnt_busy", 32'(busy), 32'd1);
        check("gnt_after_gap", 32'(cyc - done_cyc >= GAP + 1), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_gnt: got %b, expected no grant (cycle %0d)", gnt, cyc);
        end else begin
          pend = exp_q.pop_front();
          check("gnt_id", 32'(gnt), 32'(1) << pend.id);
        end
        gnt_cyc = cyc;
      end
      if (dp_start) begin
        check("start_no_gnt", 32'(gnt), 32'd0);
        check("gnt_to_start", 32'(cyc - gnt_cyc), 32'd1);
        check("start_data", 32'(dp_data), 32'(pend.word));
        start_log.push_back(cyc);
        start_cyc = cyc;
        in_job = 1'b1;
      end
      if (in_job) begin
        if (dp_done) begin
          exp_done = 1'b1;
          in_job   = 1'b0;
`ifdef SERIAL_SUM_SCHED_TMO_EN
        end else if (cyc - start_cyc == TMO) begin
          exp_done = 1'b1;
          exp_tmo  = 1'b1;
          in_job   = 1'b0;
`endif
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Raise a batch of requests; grants follow set bits in cyclic order from the model pointer.
  task automatic issue(input logic [N-1:0] mask, input logic fixed, input logic [W-1:0] fword);
    job_t j;
    int   k;
    int   last;
    last = model_ptr;
    for (int i = 0; i < N; i++) begin
      k = (model_ptr + i) % N;
      if (mask[k]) begin
        j.id   = k;
        j.word = fixed ? fword : W'($urandom);
        data[k*W +: W] = j.word;
        exp_q.push_back(j);
        n_gnt_exp++;
        last = k;
      end
    end
    req = req | mask;
    model_ptr = (last + 1) % N;
  endtask

  task automatic wait_grants();
    int t;
    t = 0;
    while (req != '0 && t < 3000) begin
      if (gnt != '0) req = req & ~gnt;
      tick();
      t++;
    end
    if (req != '0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_wait: requests %b still pending, expected none", req);
      req = '0;
    end
  endtask

  task automatic wait_idle();
    int t;
    int q;
    t = 0;
    q = 0;
    while (q < 3 && t < 3000) begin
      tick();
      t++;
      if (!busy && gnt == '0) q++;
      else q = 0;
    end
    if (q < 3) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait: busy=%b, expected 0", busy);
    end
  endtask

  task automatic check_cleared(input string name);
    check({name, "_ctl"}, 32'({gnt, dp_start, done, busy, err}), 32'd0);
    check({name, "_data"}, 32'(dp_data), 32'd0);
    check({name, "_id"}, 32'(done_id), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [W-1:0] w1;
    job_t         j;
    int           s0;
    int           t;

    rst  = 1'b1;
    req  = '0;
    data = '0;
    tick(3);
    check_cleared("reset");
    rst = 1'b0;
    tick();
    check_cleared("post_reset");

    // Single requester with a known word, done 40 cycles after start.
    w1 = 27'b000000011_000000010_000000001;
    dp_lat = 40;
    issue(4'b0001, 1'b1, w1);
    wait_grants();
    wait_idle();
    check("single_gnt_cnt", 32'(n_gnt_seen), 32'd1);
    check("single_done_id", 32'(done_id), 32'd0);

    // All four requesting continuously: fixed start-to-start spacing.
    dp_lat = LAT;
    s0 = start_log.size();
    issue(4'b1111, 1'b0, '0);
    wait_grants();
    issue(4'b1111, 1'b0, '0);
    wait_grants();
    wait_idle();
    check("rr_start_cnt", 32'(start_log.size() - s0), 32'd8);
    for (int i = s0 + 1; i < start_log.size(); i++)
      check("rr_spacing", 32'(start_log[i] - start_log[i-1]), 32'(LAT + GAP + 3));

    // Pointer at 2 with requests 0 and 1: 0 wins; request 1 is withdrawn before its turn.
    issue(4'b0010, 1'b0, '0);
    wait_grants();
    wait_idle();
    j.id = 0;
    j.word = W'($urandom);
    data[0 +: W] = j.word;
    exp_q.push_back(j);
    n_gnt_exp++;
    req = 4'b0011;
    t = 0;
    while (gnt == '0 && t < 20) begin
      tick();
      t++;
    end
    req = '0;
    model_ptr = 1;
    wait_idle();
    issue(4'b0110, 1'b0, '0);
    wait_grants();
    wait_idle();

    // Stray done pulses in IDLE and in GAP.
    spur_cnt++;
    tick(4);
    check("spur_idle_busy", 32'(busy), 32'd0);
    issue(4'b0001, 1'b0, '0);
    wait_grants();
    t = 0;
    while (!done && t < 100) begin
      tick();
      t++;
    end
    spur_cnt++;
    tick();
    check("spur_gap_busy", 32'(busy), 32'd1);
    wait_idle();

    // Reset in the middle of a job; the late done lands in IDLE.
    dp_lat = 20;
    issue(4'b0100, 1'b0, '0);
    wait_grants();
    t = 0;
    while (!dp_start && t < 20) begin
      tick();
      t++;
    end
    tick(5);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check_cleared("mid_reset");
    rst = 1'b0;
    model_ptr = 0;
    tick(25);
    check("stale_done_busy", 32'(busy), 32'd0);
    dp_lat = LAT;
    issue(4'b0101, 1'b0, '0);
    wait_grants();
    wait_idle();

    // Datapath that never answers.
    dp_auto = 1'b0;
    issue(4'b0001, 1'b0, '0);
    wait_grants();
`ifdef SERIAL_SUM_SCHED_TMO_EN
    t = 0;
    while (!done && t < 300) begin
      tick();
      t++;
    end
    check("tmo_err", 32'(err), 32'd1);
    dp_auto = 1'b1;
    issue(4'b0010, 1'b0, '0);
    wait_grants();
    wait_idle();
    check("tmo_err_sticky", 32'(err), 32'd1);
`else
    tick(200);
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_ptr = 0;
    dp_auto = 1'b1;
    tick();
`endif

    // Randomized request batches and datapath latencies.
    dp_rand = 1'b1;
    repeat (25) begin
      issue(N'($urandom_range(1, (1 << N) - 1)), 1'b0, '0);
      wait_grants();
      tick(int'($urandom_range(0, 8)));
    end
    wait_idle();

    check("gnt_total", 32'(n_gnt_seen), 32'(n_gnt_exp));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_sum_sched.md
# serial_sum_sched

Round-robin scheduler that shares one serial three-operand sum datapath among `N_REQ` requesters. Each requester presents a packed 27-bit operand word (three 9-bit fields). The scheduler grants one requester, launches the datapath with a one-cycle start pulse, holds off all other requesters until the datapath reports completion, then rotates priority. It sits between the request sources and the datapath's `start_i`/`data_i` inputs.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 27, operand word width (three 9-bit fields, unmodified by this block)
- `GAP_CYC`, 2, idle cycles enforced between datapath completion and the next start (0..15)
- `TMO_CYC`, 1023, watchdog limit in cycles from start to done (only with macro)
- `clk_i` in 1 — single clock, rising edge
- `rst_i` in 1 — synchronous, active-high reset
- `req_i` in N_REQ — level request per requester; held until granted
- `data_i` in N_REQ*DATA_W — operand words; requester k at bits [k*DATA_W +: DATA_W]
- `gnt_o` out N_REQ — one-hot, one-cycle pulse; the word of requester k is captured in that cycle
- `dp_start_o` out 1 — one-cycle start pulse to the datapath
- `dp_data_o` out DATA_W — registered operand word; stable from start until done
- `dp_done_i` in 1 — one-cycle completion pulse from the datapath
- `done_o` out 1 — one-cycle pulse; job of `done_id_o` finished
- `done_id_o` out 3 — requester index of the finished job; holds until the next done
- `busy_o` out 1 — high from grant until the GAP state is left
- `err_o` out 1 — sticky watchdog flag (constant 0 without macro)

## Operation
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE: if any `req_i` is set, pick the first set bit at or after `ptr` (cyclic search), assert `gnt_o[k]`, capture word k into `dp_data_o`, store k, go to ISSUE. If no bit is set, stay in IDLE.
- ISSUE: assert `dp_start_o` for exactly 1 cycle, clear the cycle counter, go to WAIT.
- WAIT: on `dp_done_i`, pulse `done_o` with `done_id_o`=k and set `ptr`=(k+1) mod N_REQ. Then go to GAP if `GAP_CYC`>0, else to IDLE.
- GAP: count `GAP_CYC` cycles, then go to IDLE.
- `dp_done_i` outside WAIT is ignored; it produces no `done_o`.
- A `req_i` bit that drops before its grant is simply skipped. Requests are never queued internally.
- `ptr` is 3 bits and wraps at N_REQ-1 → 0.

## Timing
- Reset values: state=IDLE, `ptr`=0, all outputs 0, `dp_data_o`=0, `done_id_o`=0.
- Request to grant: `gnt_o` is asserted in the first IDLE cycle with the request visible (registered, +1 cycle after sampling).
- Grant to start: `dp_start_o` is asserted exactly 1 cycle after `gnt_o`.
- Done to done_o: `done_o` is asserted 1 cycle after `dp_done_i` is sampled.
- Next grant: earliest at done_o + `GAP_CYC` + 1 cycles.
- `dp_start_o` and `gnt_o` are never high in the same cycle. At most one `gnt_o` bit is set at a time.
- Reset mid-job: on the next edge the block returns to IDLE with all outputs cleared. The datapath is not notified, and a stale `dp_done_i` is ignored because the block is in IDLE.

## Configuration
- `SERIAL_SUM_SCHED_TMO_EN` defined:
  - WAIT counts cycles. If the count reaches `TMO_CYC` without `dp_done_i`, set `err_o` (sticky until reset).
  - Pulse `done_o` with the current id, advance `ptr`, then go to GAP.
  - If `dp_done_i` and the timeout occur in the same cycle, done wins and `err_o` stays 0.
- Macro undefined: no counter is built, WAIT waits indefinitely, and `err_o` is tied to 0.

## Test plan
- Reset, single requester: `req_i`=4'b0001, `data_i[26:0]`=000000011_000000010_000000001, done 40 cycles after start → `gnt_o`=0001 once, `dp_data_o` equals the word, one `done_o` with id 0.
- All four request continuously, 8 jobs → grant order 0,1,2,3,0,1,2,3. Consecutive starts are exactly (done latency + `GAP_CYC` + 3) cycles apart.
- `ptr`=2, `req_i`=4'b0011 → grant to 0. Then with `req_i`=4'b0110 → grant to 1.
- Spurious `dp_done_i` in IDLE and GAP → no `done_o`, no state change. `rst_i` asserted during WAIT → all outputs 0 next cycle, next grant goes to requester 0.
- With macro, `TMO_CYC`=50, no done → `err_o`=1 and `done_o` at start+51, scheduler resumes. Without macro → `busy_o` remains 1 and `err_o`=0.
- `GAP_CYC`=0 → the grant to the next requester follows `done_o` by 1 cycle.
